// File: rtl/axi_lite_regfile_if.sv
// -----------------------------------------------------------------------------
// axi_lite_regfile_if
// AXI4-Lite slave-side bus bundle used by axi_lite_regfile.
//
// Handshake rule for every channel (AW, W, B, AR, R): a transfer happens on a
// rising clk edge where both valid and ready are 1. A source keeps valid and
// its payload stable until that edge; ready may change freely.
//
// Signals (slave view):
//   awaddr/awvalid -> awready     write address channel
//   wdata/wstrb/wvalid -> wready  write data channel
//   bresp/bvalid <- bready        write response channel (00 OKAY, 10 SLVERR)
//   araddr/arvalid -> arready     read address channel
//   rdata/rresp/rvalid <- rready  read data channel (00 OKAY, 10 SLVERR)
// -----------------------------------------------------------------------------
interface axi_lite_regfile_if #(
    parameter int ADDR_W = 12
) ();
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_regfile.sv
// -----------------------------------------------------------------------------
// axi_lite_regfile
// AXI4-Lite slave register file: NCTRL read/write control words with byte-strobe
// merge and per-word write pulses, followed by NSTAT read-only status words.
// Word index = addr[ADDR_W-1:2]; indices past the status block answer SLVERR.
//
// Ports:
//   clk, rst       single clock, synchronous active-high reset
//   s_axi          AXI4-Lite slave bundle (see axi_lite_regfile_if)
//   ctrl_out       flattened control words, word k at [32k+31:32k]
//   ctrl_wr_pulse  one-cycle strobe, bit k set after a write to word k
//   stat_in        flattened status words, captured at the AR handshake
//   dbg_state      current FSM state encoding
// -----------------------------------------------------------------------------
module axi_lite_regfile #(
    parameter int          ADDR_W   = 12,
    parameter int          NCTRL    = 4,
    parameter int          NSTAT    = 4,
    parameter logic [31:0] CTRL_RST = 32'h0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    axi_lite_regfile_if.slave                     s_axi,
    output logic [NCTRL*32-1:0]                   ctrl_out,
    output logic [NCTRL-1:0]                      ctrl_wr_pulse,
    input  logic [((NSTAT > 0) ? NSTAT : 1)*32-1:0] stat_in,
    output logic [2:0]                            dbg_state
);
    localparam int IW = ADDR_W - 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WA    = 3'd1,  // address held, waiting for data
        ST_WD    = 3'd2,  // data held, waiting for address
        ST_WRESP = 3'd3,
        ST_RDATA = 3'd4
    } state_t;

    state_t       state, state_n;
    logic [IW-1:0] aw_idx_q;
    logic [31:0]  wdata_q;
    logic [3:0]   wstrb_q;
    logic [31:0]  ctrl_q [NCTRL];
    logic [1:0]   bresp_q, rresp_q;
    logic [31:0]  rdata_q;

    logic          awready_c, wready_c, arready_c;
    logic          aw_cap, w_cap, commit, rd_fire;
    logic [IW-1:0] c_idx;
    logic [31:0]   c_data;
    logic [3:0]    c_strb;
    logic [IW-1:0] aw_idx, ar_idx;
    logic [31:0]   rd_word;
    logic          rd_hit;
    logic          unused_addr_lsbs;

    assign aw_idx = s_axi.awaddr[ADDR_W-1:2];
    assign ar_idx = s_axi.araddr[ADDR_W-1:2];
    assign unused_addr_lsbs = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0]};

    // Next state and channel readiness. Commit is raised in the cycle the
    // second half of a write handshakes; c_* select the held or live half.
    always_comb begin
        state_n   = state;
        awready_c = 1'b0;
        wready_c  = 1'b0;
        arready_c = 1'b0;
        aw_cap    = 1'b0;
        w_cap     = 1'b0;
        commit    = 1'b0;
        rd_fire   = 1'b0;
        c_idx     = aw_idx_q;
        c_data    = wdata_q;
        c_strb    = wstrb_q;
        case (state)
            ST_IDLE: begin
                awready_c = 1'b1;
                wready_c  = 1'b1;
                // Writes take priority: a read is only accepted when no write half is offered.
                arready_c = !(s_axi.awvalid || s_axi.wvalid);
                if (s_axi.awvalid && s_axi.wvalid) begin
                    commit  = 1'b1;
                    c_idx   = aw_idx;
                    c_data  = s_axi.wdata;
                    c_strb  = s_axi.wstrb;
                    state_n = ST_WRESP;
                end else if (s_axi.awvalid) begin
                    aw_cap  = 1'b1;
                    state_n = ST_WA;
                end else if (s_axi.wvalid) begin
                    w_cap   = 1'b1;
                    state_n = ST_WD;
                end else if (s_axi.arvalid) begin
                    rd_fire = 1'b1;
                    state_n = ST_RDATA;
                end
            end
            ST_WA: begin
                wready_c = 1'b1;
                if (s_axi.wvalid) begin
                    commit  = 1'b1;
                    c_data  = s_axi.wdata;
                    c_strb  = s_axi.wstrb;
                    state_n = ST_WRESP;
                end
            end
            ST_WD: begin
                awready_c = 1'b1;
                if (s_axi.awvalid) begin
                    commit  = 1'b1;
                    c_idx   = aw_idx;
                    state_n = ST_WRESP;
                end
            end
            ST_WRESP: if (s_axi.bready) state_n = ST_IDLE;
            ST_RDATA: if (s_axi.rready) state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // Read decode over the combined control + status map.
    always_comb begin
        rd_word = '0;
        rd_hit  = 1'b0;
        for (int k = 0; k < NCTRL; k++) begin
            if (ar_idx == IW'(k)) begin
                rd_word = ctrl_q[k];
                rd_hit  = 1'b1;
            end
        end
        for (int k = 0; k < NSTAT; k++) begin
            if (ar_idx == IW'(NCTRL + k)) begin
                rd_word = stat_in[32*k +: 32];
                rd_hit  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            aw_idx_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            ctrl_wr_pulse <= '0;
            bresp_q       <= 2'b00;
            rresp_q       <= 2'b00;
            rdata_q       <= '0;
            for (int k = 0; k < NCTRL; k++) ctrl_q[k] <= CTRL_RST;
        end else begin
            state         <= state_n;
            ctrl_wr_pulse <= '0;
            if (aw_cap) aw_idx_q <= aw_idx;
            if (w_cap) begin
                wdata_q <= s_axi.wdata;
                wstrb_q <= s_axi.wstrb;
            end
            if (commit) begin
                bresp_q <= 2'b10;
                for (int k = 0; k < NCTRL; k++) begin
                    if (c_idx == IW'(k)) begin
                        for (int b = 0; b < 4; b++) begin
                            if (c_strb[b]) ctrl_q[k][8*b +: 8] <= c_data[8*b +: 8];
                        end
                        // Pulse even with an all-zero strobe: the write still happened.
                        ctrl_wr_pulse[k] <= 1'b1;
                        bresp_q          <= 2'b00;
                    end
                end
            end
            if (rd_fire) begin
                rdata_q <= rd_word;
                rresp_q <= rd_hit ? 2'b00 : 2'b10;
            end
        end
    end

    assign s_axi.awready = awready_c & ~rst;
    assign s_axi.wready  = wready_c & ~rst;
    assign s_axi.arready = arready_c & ~rst;
    assign s_axi.bvalid  = (state == ST_WRESP);
    assign s_axi.bresp   = bresp_q;
    assign s_axi.rvalid  = (state == ST_RDATA);
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;
    assign dbg_state     = state;

    for (genvar k = 0; k < NCTRL; k++) begin : g_ctrl_out
        assign ctrl_out[32*k +: 32] = ctrl_q[k];
    end
endmodule

// File: tb/tb_axi_lite_regfile.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_regfile
// Self-checking bench for axi_lite_regfile (NCTRL=4, NSTAT=4, nonzero reset
// value). Directed vector table, two hand-written corner sequences (write/read
// collision, reset while a write half is held) and a randomized phase checked
// against a word-array model of the register map.
// -----------------------------------------------------------------------------
module tb_axi_lite_regfile;
    localparam int          ADDR_W  = 12;
    localparam int          NCTRL   = 4;
    localparam int          NSTAT   = 4;
    localparam logic [31:0] RST_VAL = 32'hA5A5_0000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_lite_regfile_if #(.ADDR_W(ADDR_W)) bus ();
    logic [NCTRL*32-1:0] ctrl_out;
    logic [NCTRL-1:0]    ctrl_wr_pulse;
    logic [NSTAT*32-1:0] stat_in;
    logic [2:0]          dbg_state;

    axi_lite_regfile #(
        .ADDR_W(ADDR_W), .NCTRL(NCTRL), .NSTAT(NSTAT), .CTRL_RST(RST_VAL)
    ) dut (
        .clk(clk), .rst(rst), .s_axi(bus),
        .ctrl_out(ctrl_out), .ctrl_wr_pulse(ctrl_wr_pulse),
        .stat_in(stat_in), .dbg_state(dbg_state)
    );

    // ---------------- reference model / scoreboard ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] model_ctrl [NCTRL];
    logic [31:0] stat_w [NSTAT];
    logic [31:0] exp_q [$];

    always_comb begin
        for (int k = 0; k < NSTAT; k++) stat_in[32*k +: 32] = stat_w[k];
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < NCTRL; k++) model_ctrl[k] = RST_VAL;
    endfunction

    function automatic logic [NCTRL*32-1:0] model_flat();
        logic [NCTRL*32-1:0] f;
        for (int k = 0; k < NCTRL; k++) f[32*k +: 32] = model_ctrl[k];
        return f;
    endfunction

    function automatic void model_write(input logic [11:0] addr, input logic [31:0] d,
                                        input logic [3:0] s, output logic [1:0] resp,
                                        output logic [NCTRL-1:0] pm);
        int idx;
        idx  = int'(addr[11:2]);
        pm   = '0;
        resp = 2'b10;
        if (idx < NCTRL) begin
            for (int b = 0; b < 4; b++) if (s[b]) model_ctrl[idx][8*b +: 8] = d[8*b +: 8];
            pm[idx] = 1'b1;
            resp    = 2'b00;
        end
    endfunction

    function automatic void model_read(input logic [11:0] addr, output logic [31:0] d,
                                       output logic [1:0] resp);
        int idx;
        idx  = int'(addr[11:2]);
        d    = 32'h0;
        resp = 2'b10;
        if (idx < NCTRL) begin
            d    = model_ctrl[idx];
            resp = 2'b00;
        end else if (idx < NCTRL + NSTAT) begin
            d    = stat_w[idx - NCTRL];
            resp = 2'b00;
        end
    endfunction

    // ---------------- driver tasks (entered and left at a negedge) ----------------
    task automatic do_write(input logic [11:0] addr, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int b_dly,
                            output logic [1:0] got_resp);
        bit aw_done, w_done, hs_aw, hs_w;
        int cyc;
        logic [1:0] er;
        logic [NCTRL-1:0] epm;
        aw_done = 0; w_done = 0; cyc = 0;
        bus.awaddr = addr; bus.wdata = d; bus.wstrb = s;
        while (!(aw_done && w_done) && cyc < 40) begin
            bus.awvalid = !aw_done && (cyc >= aw_dly);
            bus.wvalid  = !w_done && (cyc >= w_dly);
            #1;
            hs_aw = bus.awvalid && bus.awready;
            hs_w  = bus.wvalid && bus.wready;
            @(posedge clk);
            aw_done = aw_done | hs_aw;
            w_done  = w_done | hs_w;
            cyc++;
            @(negedge clk);
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        chk("wr_handshake", {aw_done, w_done}, 2'b11);
        model_write(addr, d, s, er, epm);
        chk("bvalid", bus.bvalid, 1'b1);
        chk("bresp", bus.bresp, er);
        chk("wr_pulse", ctrl_wr_pulse, epm);
        chk("ctrl_out", ctrl_out, model_flat());
        got_resp = bus.bresp;
        for (int i = 0; i < b_dly; i++) begin
            @(posedge clk); @(negedge clk);
            chk("bvalid_hold", bus.bvalid, 1'b1);
            chk("pulse_one_cycle", ctrl_wr_pulse, '0);
        end
        bus.bready = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.bready = 1'b0;
        chk("bvalid_drop", bus.bvalid, 1'b0);
        chk("pulse_clear", ctrl_wr_pulse, '0);
    endtask

    task automatic do_read(input logic [11:0] addr, input int r_dly,
                           output logic [31:0] got_d, output logic [1:0] got_resp);
        bit done;
        int cyc;
        logic [31:0] ed, exp_d;
        logic [1:0] er, exp_r;
        done = 0; cyc = 0; exp_r = 2'b10;
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        while (!done && cyc < 40) begin
            #1;
            if (bus.arready) begin
                model_read(addr, ed, er);
                exp_q.push_back(ed);
                exp_r = er;
                done  = 1;
            end
            @(posedge clk); @(negedge clk);
            cyc++;
        end
        bus.arvalid = 1'b0;
        chk("rd_handshake", done, 1'b1);
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
        chk("rvalid", bus.rvalid, 1'b1);
        chk("rdata", bus.rdata, exp_d);
        chk("rresp", bus.rresp, exp_r);
        got_d    = bus.rdata;
        got_resp = bus.rresp;
        for (int i = 0; i < r_dly; i++) begin
            for (int k = 0; k < NSTAT; k++) stat_w[k] = ~stat_w[k];
            @(posedge clk); @(negedge clk);
            chk("rvalid_hold", bus.rvalid, 1'b1);
            chk("rdata_stable", bus.rdata, exp_d);
        end
        bus.rready = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.rready = 1'b0;
        chk("rvalid_drop", bus.rvalid, 1'b0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          is_rd;
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_dly;
        int          w_dly;
        int          hold;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NV = 14;
    vec_t vt [NV];

    initial begin
        logic [31:0] gd;
        logic [1:0]  gr;
        logic [31:0] ed;
        logic [1:0]  er;
        logic [NCTRL-1:0] epm;
        logic [11:0] ra;
        int          rk;

        vt[0]  = '{0, 12'h004, 32'hDEADBEEF, 4'hF, 0, 0, 1, 2'b00, 32'h0};
        vt[1]  = '{0, 12'h000, 32'h000000AA, 4'h1, 2, 0, 0, 2'b00, 32'h0};
        vt[2]  = '{1, 12'h000, 32'h0, 4'h0, 0, 0, 0, 2'b00, {RST_VAL[31:8], 8'hAA}};
        vt[3]  = '{1, 12'h004, 32'h0, 4'h0, 0, 0, 2, 2'b00, 32'hDEADBEEF};
        vt[4]  = '{0, 12'h004, 32'h11223344, 4'h5, 0, 1, 0, 2'b00, 32'h0};
        vt[5]  = '{1, 12'h004, 32'h0, 4'h0, 0, 0, 0, 2'b00, 32'hDE22BE44};
        vt[6]  = '{0, 12'h010, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 2'b10, 32'h0};
        vt[7]  = '{1, 12'h3FC, 32'h0, 4'h0, 0, 0, 1, 2'b10, 32'h0};
        vt[8]  = '{1, 12'h010, 32'h0, 4'h0, 0, 0, 3, 2'b00, 32'h12345678};
        vt[9]  = '{0, 12'h00C, 32'h00000055, 4'h0, 1, 1, 0, 2'b00, 32'h0};
        vt[10] = '{1, 12'h00C, 32'h0, 4'h0, 0, 0, 0, 2'b00, RST_VAL};
        vt[11] = '{1, 12'h01C, 32'h0, 4'h0, 0, 0, 0, 2'b00, 32'hCAFEF00D};
        vt[12] = '{0, 12'h020, 32'h01020304, 4'hF, 1, 0, 0, 2'b10, 32'h0};
        vt[13] = '{1, 12'h020, 32'h0, 4'h0, 0, 0, 0, 2'b10, 32'h0};

        bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0;
        bus.bready = 0; bus.araddr = '0; bus.arvalid = 0; bus.rready = 0;
        for (int k = 0; k < NSTAT; k++) stat_w[k] = '0;
        model_reset();

        // ---- reset state ----
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.awvalid = 1; bus.wvalid = 1; bus.arvalid = 1;
        #1;
        chk("rst_awready", bus.awready, 1'b0);
        chk("rst_wready", bus.wready, 1'b0);
        chk("rst_arready", bus.arready, 1'b0);
        chk("rst_bvalid", bus.bvalid, 1'b0);
        chk("rst_rvalid", bus.rvalid, 1'b0);
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst_bresp", bus.bresp, 2'b00);
        chk("rst_rresp", bus.rresp, 2'b00);
        chk("rst_ctrl_out", ctrl_out, {NCTRL{RST_VAL}});
        chk("rst_pulse", ctrl_wr_pulse, '0);
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        #1;
        chk("idle_awready", bus.awready, 1'b1);
        chk("idle_arready", bus.arready, 1'b1);
        @(negedge clk);

        // ---- table ----
        for (int i = 0; i < NV; i++) begin
            stat_w[0] = 32'h12345678; stat_w[1] = 32'h0BADF00D;
            stat_w[2] = 32'h9ABCDEF0; stat_w[3] = 32'hCAFEF00D;
            if (vt[i].is_rd) begin
                do_read(vt[i].addr, vt[i].hold, gd, gr);
                chk($sformatf("vec%0d_rdata", i), gd, vt[i].exp_rdata);
                chk($sformatf("vec%0d_rresp", i), gr, vt[i].exp_resp);
            end else begin
                do_write(vt[i].addr, vt[i].data, vt[i].strb, vt[i].aw_dly, vt[i].w_dly,
                         vt[i].hold, gr);
                chk($sformatf("vec%0d_bresp", i), gr, vt[i].exp_resp);
            end
        end

        // ---- AW, W and AR offered together: write first, read after BREADY ----
        bus.awaddr = 12'h008; bus.wdata = 32'h5A5A1234; bus.wstrb = 4'hF;
        bus.araddr = 12'h008;
        bus.awvalid = 1; bus.wvalid = 1; bus.arvalid = 1;
        #1;
        chk("col_arready_low", bus.arready, 1'b0);
        chk("col_awready", bus.awready, 1'b1);
        chk("col_wready", bus.wready, 1'b1);
        @(posedge clk); @(negedge clk);
        bus.awvalid = 0; bus.wvalid = 0;
        model_write(12'h008, 32'h5A5A1234, 4'hF, er, epm);
        #1;
        chk("col_bvalid", bus.bvalid, 1'b1);
        chk("col_bresp", bus.bresp, er);
        chk("col_pulse", ctrl_wr_pulse, epm);
        chk("col_arready_wresp", bus.arready, 1'b0);
        bus.bready = 1;
        @(posedge clk); @(negedge clk);
        bus.bready = 0;
        #1;
        chk("col_bvalid_drop", bus.bvalid, 1'b0);
        chk("col_arready_idle", bus.arready, 1'b1);
        model_read(12'h008, ed, er);
        @(posedge clk); @(negedge clk);
        bus.arvalid = 0;
        chk("col_rvalid", bus.rvalid, 1'b1);
        chk("col_rdata_model", bus.rdata, ed);
        chk("col_rdata_new", bus.rdata, 32'h5A5A1234);
        bus.rready = 1;
        @(posedge clk); @(negedge clk);
        bus.rready = 0;
        chk("col_rvalid_drop", bus.rvalid, 1'b0);

        // ---- reset while address is held: write discarded, no response ----
        bus.awaddr = 12'h004; bus.awvalid = 1;
        #1;
        chk("wa_awready", bus.awready, 1'b1);
        @(posedge clk); @(negedge clk);
        bus.awvalid = 0;
        #1;
        chk("wa_wready", bus.wready, 1'b1);
        chk("wa_awready_low", bus.awready, 1'b0);
        rst = 1; bus.wdata = 32'hFFFFFFFF; bus.wstrb = 4'hF; bus.wvalid = 1;
        #1;
        chk("wa_rst_wready", bus.wready, 1'b0);
        @(posedge clk); @(negedge clk);
        rst = 0; bus.wvalid = 0;
        model_reset();
        chk("wa_rst_bvalid", bus.bvalid, 1'b0);
        chk("wa_rst_pulse", ctrl_wr_pulse, '0);
        chk("wa_rst_ctrl", ctrl_out, model_flat());
        @(posedge clk); @(negedge clk);
        chk("wa_rst_bvalid2", bus.bvalid, 1'b0);
        chk("wa_rst_pulse2", ctrl_wr_pulse, '0);
        chk("wa_rst_ctrl2", ctrl_out, {NCTRL{RST_VAL}});
        #1;
        chk("wa_rst_idle", {bus.awready, bus.wready, bus.arready}, 3'b111);
        @(negedge clk);

        // ---- randomized traffic against the model ----
        repeat (60) begin
            rk = $urandom_range(0, 10);
            ra = (rk == 10) ? 12'h3FC : 12'(rk * 4);
            for (int k = 0; k < NSTAT; k++) stat_w[k] = $urandom;
            if ($urandom_range(0, 1) == 1)
                do_read(ra, $urandom_range(0, 3), gd, gr);
            else
                do_write(ra, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 2), gr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/axi_lite_regfile.md
Name: axi_lite_regfile

Overview:
Parametrised AXI4-Lite slave register file that replaces the fixed two-bit {com, run} control register in the accelerator top. It provides NCTRL read/write control words with byte-strobe merging and per-register write pulses, plus NSTAT read-only status words sampled from the core. It adds SLVERR decoding for unmapped addresses. It sits between the PS AXI-Lite port and the accelerator control signals (run, com, store/last counters, etc.).

Parameters:
ADDR_W, 12, AXI-Lite address width; word index = addr[ADDR_W-1:2]
NCTRL, 4, number of RW control words (1..64)
NSTAT, 4, number of RO status words (0..64)
CTRL_RST, 0, 32-bit reset value applied to every control word

Ports:
clk  in  1  single clock (AXI-Lite and core domain)
rst  in  1  synchronous, active-high reset
S_AXI_AWADDR  in  ADDR_W  write address
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  ADDR_W  read address
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  00 OKAY, 10 SLVERR
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
ctrl_out  out  NCTRL*32  flattened control words, word k at [32k+31:32k]
ctrl_wr_pulse  out  NCTRL  one-cycle strobe: word k was written
stat_in  in  NSTAT*32  flattened status words, sampled at AR handshake

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; ctrl words = CTRL_RST; ctrl_wr_pulse=0; BVALID=RVALID=0; RDATA=0; BRESP=RRESP=00. All READY outputs are forced to 0 while rst=1.
- Address map: word index i < NCTRL is control word i (RW). NCTRL <= i < NCTRL+NSTAT is status word i-NCTRL (RO). Any other index is unmapped.
- FSM states: IDLE, WA (have address, need data), WD (have data, need address), WRESP, RDATA.
- IDLE: AWREADY=WREADY=ARREADY=1.
  - AWVALID&WVALID -> capture both, go WRESP.
  - AWVALID only -> capture address, go WA.
  - WVALID only -> capture data and strobe, go WD.
  - ARVALID with no write valid -> go RDATA. Writes win over a simultaneous read; ARREADY is deasserted that cycle via combinational gating.
- WA: WREADY=1 only; on WVALID go WRESP. WD: AWREADY=1 only; on AWVALID go WRESP.
- Commit on entry to WRESP, i.e. in the cycle the second half handshakes:
  - Control index: merge byte lane b when WSTRB[b]=1; ctrl_wr_pulse[k]=1 for exactly that cycle, even if WSTRB=0; BRESP=00.
  - Status or unmapped index: no state change, no pulse, BRESP=10.
- WRESP: BVALID=1 until BREADY, then return to IDLE. The earliest next AW/W acceptance is the cycle after BREADY.
- RDATA: RDATA/RRESP are registered at the AR handshake, so status reflects stat_in in the handshake cycle.
  - RVALID=1 in the next cycle and holds, with RDATA stable, until RREADY; then IDLE.
  - Unmapped read: RDATA=0, RRESP=10. Control read returns the current ctrl word; status read returns RRESP=00.
- Latency: write pulse appears 1 cycle after the final AW/W handshake edge; read data is valid 1 cycle after the AR handshake.
- ctrl_out is updated only by writes and reset; the core never modifies it.
- Reset mid-transaction aborts it: no response is issued, and a pending, uncommitted write is discarded.

Test Plan:
- AW and W in the same cycle, addr 0x004, data 0xDEADBEEF, WSTRB 1111 -> BVALID next cycle with BRESP 00; ctrl_out[63:32]=0xDEADBEEF; ctrl_wr_pulse=0010 for one cycle.
- W two cycles before AW, addr 0x000, data 0x000000AA, WSTRB 0001, after reset -> word0=0x000000AA, with upper bytes still CTRL_RST.
- Read addr 0x010 (first status word, NCTRL=4) with stat_in word0=0x12345678 and RREADY held low 3 cycles -> RVALID stays 1, RDATA=0x12345678 stable, RRESP 00.
- Write to 0x010 and read of 0x3FC -> write gives BRESP 10 with ctrl unchanged and no pulse; read gives RDATA 0, RRESP 10.
- AWVALID, WVALID and ARVALID all high in one cycle -> write served first, ARREADY=0 that cycle; read accepted after BREADY and returns the new value.
- Assert rst while in WA -> next cycle IDLE, all ctrl words = CTRL_RST, BVALID 0, no pulse.
